// File: rtl/alu_pkg.sv
// Shared constants for the 16-bit ALU.
//   W             : operand/result width (flag semantics assume 16)
//   OP_*          : opcode encodings (OP_SHL..OP_ROL are used only when
//                   ALU_SHIFT_EN is defined)
//   FLG_*         : bit positions inside the 5-bit flag vector
package alu_pkg;

  localparam int W = 16;

  localparam logic [3:0] OP_ADC  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_MOVA = 4'd6;
  localparam logic [3:0] OP_MOVB = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SAR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
  localparam int FLG_P = 4;

endpackage

// File: rtl/alu_flags.sv
// Status flag builder for the ALU.
// Derives Z/N/P from the result and merges in the op-specific C/V bits.
// Ports:
//   res   in  W  result of the current operation
//   c     in  1  carry/borrow/shifted-out bit
//   v     in  1  signed overflow
//   flg   out 5  {P, V, N, Z, C}
module alu_flags
  import alu_pkg::*;
(
  input  logic [W-1:0] res,
  input  logic         c,
  input  logic         v,
  output logic [4:0]   flg
);

  always_comb begin
    flg        = '0;
    flg[FLG_C] = c;
    flg[FLG_Z] = (res == '0);
    flg[FLG_N] = res[W-1];
    flg[FLG_V] = v;
    flg[FLG_P] = ^res;   // odd number of ones
  end

endmodule

// File: rtl/alu.sv
// 16-bit arithmetic/logic unit with a clocked flag register.
// res/out_flg are purely combinational from opcode/arg1/arg2/in_flg;
// flg_q captures out_flg on a rising clk edge when flg_we is high.
// Optional feature macro: ALU_SHIFT_EN enables shift/rotate opcodes 8-11
// (shift amount arg2[3:0]); without it opcodes 8-15 produce res=0.
// Ports:
//   clk      in  1   clock for flg_q
//   rst      in  1   async active-high reset (flg_q only)
//   opcode   in  4   operation select
//   arg1     in  W   operand A
//   arg2     in  W   operand B
//   in_flg   in  5   incoming flags; only bit C is used (ADC carry-in)
//   flg_we   in  1   load enable for flg_q
//   res      out W   result
//   out_flg  out 5   {P, V, N, Z, C} of current op
//   flg_q    out 5   registered flags
module alu
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   opcode,
  input  logic [W-1:0] arg1,
  input  logic [W-1:0] arg2,
  input  logic [4:0]   in_flg,
  input  logic         flg_we,
  output logic [W-1:0] res,
  output logic [4:0]   out_flg,
  output logic [4:0]   flg_q
);

  logic [W-1:0] alu_res;
  logic         alu_c;
  logic         alu_v;
  logic [W:0]   sum;
  logic [4:0]   flg_d;

  // Only the carry bit of the incoming flags feeds the datapath.
  logic unused_in_flg;
  assign unused_in_flg = ^in_flg[4:1];

`ifdef ALU_SHIFT_EN
  logic [3:0]     shamt;
  logic [W:0]     shl_w;
  logic [W:0]     shr_w;
  logic [W:0]     sar_w;
  logic [2*W-1:0] rol_w;
`endif

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum     = '0;
`ifdef ALU_SHIFT_EN
    shamt = arg2[3:0];
    // Extra bit on the outgoing side holds the last bit shifted out.
    shl_w = {1'b0, arg1} << shamt;
    shr_w = {arg1, 1'b0} >> shamt;
    sar_w = $signed({arg1, 1'b0}) >>> shamt;
    rol_w = {arg1, arg1} << shamt;
`endif
    case (opcode)
      OP_ADC: begin
        sum     = {1'b0, arg1} + {1'b0, arg2} + {{W{1'b0}}, in_flg[FLG_C]};
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (arg1[W-1] == arg2[W-1]) && (alu_res[W-1] != arg1[W-1]);
      end
      OP_SUB: begin
        // The 17-bit difference wraps, so bit W is the unsigned borrow.
        sum     = {1'b0, arg1} - {1'b0, arg2};
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (arg1[W-1] != arg2[W-1]) && (alu_res[W-1] != arg1[W-1]);
      end
      OP_AND:  alu_res = arg1 & arg2;
      OP_OR:   alu_res = arg1 | arg2;
      OP_XOR:  alu_res = arg1 ^ arg2;
      OP_NOT:  alu_res = ~arg1;
      OP_MOVA: alu_res = arg1;
      OP_MOVB: alu_res = arg2;
`ifdef ALU_SHIFT_EN
      OP_SHL: begin
        alu_res = shl_w[W-1:0];
        alu_c   = shl_w[W];
      end
      OP_SHR: begin
        alu_res = shr_w[W:1];
        alu_c   = shr_w[0];
      end
      OP_SAR: begin
        alu_res = sar_w[W:1];
        alu_c   = sar_w[0];
      end
      OP_ROL: begin
        alu_res = rol_w[2*W-1:W];
        alu_c   = (shamt != 4'd0) && rol_w[W];
      end
`endif
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
    endcase
  end

  assign res = alu_res;

  alu_flags u_flags (
    .res (alu_res),
    .c   (alu_c),
    .v   (alu_v),
    .flg (out_flg)
  );

  always_comb begin
    flg_d = flg_q;
    if (flg_we) flg_d = out_flg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flg_q <= '0;
    else     flg_q <= flg_d;
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu. Expected {res, out_flg} pairs are pushed to
// exp_q as stimulus is applied and popped when the outputs are sampled.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic [15:0] arg1;
  logic [15:0] arg2;
  logic [4:0]  in_flg;
  logic        flg_we;
  logic [15:0] res;
  logic [4:0]  out_flg;
  logic [4:0]  flg_q;

  logic [20:0] exp_q[$];
  int checks;
  int errors;

  alu dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .arg1    (arg1),
    .arg2    (arg2),
    .in_flg  (in_flg),
    .flg_we  (flg_we),
    .res     (res),
    .out_flg (out_flg),
    .flg_q   (flg_q)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  // Applies one operation on the falling edge and records its expectation.
  task automatic drive_op(input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [4:0] fin,
                          input logic [20:0] want);
    @(negedge clk);
    opcode = op;
    arg1   = a;
    arg2   = b;
    in_flg = fin;
    exp_q.push_back(want);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [20:0] exp, got;
    rst    = 1'b1;
    flg_we = 1'b1;
    drive_op(OP_ADC, 16'd2, 16'd3, 5'b0, {16'd5, 5'b00000});
    @(posedge clk);
    #1;
    checks++;
    if (flg_q !== 5'b0) begin
      errors++;
      $display("FAIL reset_flg_q: got %b expected %b", flg_q, 5'b0);
    end
    // Combinational path keeps working while reset is held.
    got = {res, out_flg};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_comb: got res=%h flg=%b expected res=%h flg=%b",
               got[20:5], got[4:0], exp[20:5], exp[4:0]);
    end
    @(negedge clk);
    flg_we = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic test_adc();
    logic [15:0] a_t [4];
    logic [15:0] b_t [4];
    logic [20:0] w_t [4];
    logic [20:0] exp, got;
    logic [4:0]  fin;
    a_t = '{16'hFFFF, 16'd1, 16'h7FFF, 16'hFFFF};
    b_t = '{16'd5,    16'd1, 16'd1,    16'd1};
    w_t = '{{16'd4, 5'b10001}, {16'd3, 5'b00000},
            {16'h8000, 5'b11100}, {16'h0000, 5'b00011}};
    fin = 5'b0;
    for (int i = 0; i < 4; i++) begin
      // Entry 1 chains the carry produced by entry 0.
      if (i == 1) fin = out_flg;
      else        fin = 5'b0;
      drive_op(OP_ADC, a_t[i], b_t[i], fin, w_t[i]);
      got = {res, out_flg};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL adc_%0d: got res=%h flg=%b expected res=%h flg=%b",
                 i, got[20:5], got[4:0], exp[20:5], exp[4:0]);
      end
    end
    // Upper in_flg bits must not leak into the sum.
    drive_op(OP_ADC, 16'd1, 16'd1, 5'b11110, {16'd2, 5'b10000});
    got = {res, out_flg};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL adc_ignore_hi: got res=%h flg=%b expected res=%h flg=%b",
               got[20:5], got[4:0], exp[20:5], exp[4:0]);
    end
  endtask

  task automatic test_sub();
    logic [15:0] a_t [4];
    logic [15:0] b_t [4];
    logic [20:0] w_t [4];
    logic [20:0] exp, got;
    a_t = '{16'd7, 16'd5, 16'h8000, 16'd5};
    b_t = '{16'd5, 16'd7, 16'd1,    16'd5};
    w_t = '{{16'd2, 5'b10000}, {16'd65534, 5'b10101},
            {16'h7FFF, 5'b11000}, {16'd0, 5'b00010}};
    for (int i = 0; i < 4; i++) begin
      // Carry-in set to show SUB has no borrow-in.
      drive_op(OP_SUB, a_t[i], b_t[i], 5'b00001, w_t[i]);
      got = {res, out_flg};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sub_%0d: got res=%h flg=%b expected res=%h flg=%b",
                 i, got[20:5], got[4:0], exp[20:5], exp[4:0]);
      end
    end
  endtask

  task automatic test_logic();
    logic [3:0]  op_t [6];
    logic [20:0] w_t [6];
    logic [20:0] exp, got;
    op_t = '{OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOVA, OP_MOVB};
    w_t  = '{{16'd5, 5'b00000}, {16'd7, 5'b10000}, {16'd2, 5'b10000},
             {16'd65528, 5'b10100}, {16'd7, 5'b10000}, {16'd5, 5'b00000}};
    for (int i = 0; i < 6; i++) begin
      drive_op(op_t[i], 16'd7, 16'd5, 5'b00001, w_t[i]);
      got = {res, out_flg};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL logic_op%0d: got res=%h flg=%b expected res=%h flg=%b",
                 op_t[i], got[20:5], got[4:0], exp[20:5], exp[4:0]);
      end
    end
  endtask

  task automatic test_upper_ops();
    logic [3:0]  op_t [6];
    logic [15:0] a_t [6];
    logic [15:0] b_t [6];
    logic [20:0] w_t [6];
    logic [20:0] exp, got;
`ifdef ALU_SHIFT_EN
    op_t = '{OP_SHL, OP_SAR, OP_SHR, OP_ROL, OP_SHL, 4'd12};
    a_t  = '{16'h8001, 16'h8000, 16'h8001, 16'h8001, 16'h8001, 16'h1234};
    b_t  = '{16'd1,    16'd15,   16'd1,    16'd1,    16'd0,    16'd1};
    w_t  = '{{16'h0002, 5'b10001}, {16'hFFFF, 5'b00100},
             {16'h4000, 5'b10001}, {16'h0003, 5'b00001},
             {16'h8001, 5'b00100}, {16'h0000, 5'b00010}};
`else
    op_t = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
    a_t  = '{16'h8001, 16'h8000, 16'hFFFF, 16'h1234, 16'h0001, 16'hAAAA};
    b_t  = '{16'd1, 16'd15, 16'd1, 16'd3, 16'd0, 16'h5555};
    for (int i = 0; i < 6; i++) w_t[i] = {16'h0000, 5'b00010};
`endif
    for (int i = 0; i < 6; i++) begin
      drive_op(op_t[i], a_t[i], b_t[i], 5'b00001, w_t[i]);
      got = {res, out_flg};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL upper_op%0d: got res=%h flg=%b expected res=%h flg=%b",
                 op_t[i], got[20:5], got[4:0], exp[20:5], exp[4:0]);
      end
    end
  endtask

  // Random ADC/SUB against an integer reference model.
  task automatic test_random_arith();
    logic [20:0] exp, got;
    logic [3:0]  op;
    logic [15:0] a, b, r;
    logic [4:0]  fin, f;
    int          s;
    for (int i = 0; i < 40; i++) begin
      op  = ($urandom_range(0, 1) == 0) ? OP_ADC : OP_SUB;
      a   = 16'($urandom_range(0, 65535));
      b   = 16'($urandom_range(0, 65535));
      fin = 5'($urandom_range(0, 31));
      f   = 5'b0;
      if (op == OP_ADC) begin
        s = int'(a) + int'(b) + int'(fin[0]);
        r = 16'(s);
        f[FLG_C] = (s > 65535);
        f[FLG_V] = ($signed(a) + $signed(b) + int'(fin[0]) > 32767) ||
                   ($signed(a) + $signed(b) + int'(fin[0]) < -32768);
      end else begin
        s = int'(a) - int'(b);
        r = 16'(s);
        f[FLG_C] = (a < b);
        f[FLG_V] = ($signed(a) - $signed(b) > 32767) ||
                   ($signed(a) - $signed(b) < -32768);
      end
      f[FLG_Z] = (r == 16'd0);
      f[FLG_N] = r[15];
      f[FLG_P] = ^r;
      drive_op(op, a, b, fin, {r, f});
      got = {res, out_flg};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rand_%0d op%0d a=%h b=%h: got res=%h flg=%b expected res=%h flg=%b",
                 i, op, a, b, got[20:5], got[4:0], exp[20:5], exp[4:0]);
      end
    end
  endtask

  task automatic test_flag_reg();
    logic [4:0] exp_f;
    // Load on edge when enabled.
    @(negedge clk);
    opcode = OP_SUB; arg1 = 16'd7; arg2 = 16'd5; in_flg = 5'b0; flg_we = 1'b1;
    @(posedge clk);
    #1;
    exp_f = 5'b10000;
    checks++;
    if (flg_q !== exp_f) begin
      errors++;
      $display("FAIL flg_load: got %b expected %b", flg_q, exp_f);
    end
    // Hold when disabled even though out_flg changes.
    @(negedge clk);
    flg_we = 1'b0; opcode = OP_AND;
    @(posedge clk);
    #1;
    checks++;
    if (flg_q !== exp_f) begin
      errors++;
      $display("FAIL flg_hold: got %b expected %b", flg_q, exp_f);
    end
    // Back-to-back loads.
    @(negedge clk);
    flg_we = 1'b1; opcode = OP_ADC; arg1 = 16'hFFFF; arg2 = 16'd1;
    @(posedge clk);
    #1;
    exp_f = 5'b00011;
    checks++;
    if (flg_q !== exp_f) begin
      errors++;
      $display("FAIL flg_load2: got %b expected %b", flg_q, exp_f);
    end
    // Mid-cycle async reset clears immediately.
    @(negedge clk);
    flg_we = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (flg_q !== 5'b0) begin
      errors++;
      $display("FAIL flg_async_rst: got %b expected %b", flg_q, 5'b0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (flg_q !== 5'b0) begin
      errors++;
      $display("FAIL flg_after_rst: got %b expected %b", flg_q, 5'b0);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    opcode = OP_MOVA;
    arg1   = '0;
    arg2   = '0;
    in_flg = '0;
    flg_we = 1'b0;
    test_reset();
    test_adc();
    test_sub();
    test_logic();
    test_upper_ops();
    test_random_arith();
    test_flag_reg();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
